// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT lifecycle, fetch address and retired-instruction count.
// pc/count update one cycle after the deciding edge; stall holds all RUN state, no other backpressure.
module pc_sequencer #(
   parameter int PC_W      = 10,
   parameter int CNT_W     = 16,
   parameter int MAX_INSTR = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PC_W-1:0]  start_addr,
   input  logic             stall,
   input  logic             branch,
   input  logic [PC_W-1:0]  target,
   input  logic             halt_instr,
   output logic [PC_W-1:0]  pc,
   output logic             running,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_INSTR - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t           state_q, state_nxt;
   logic [PC_W-1:0]  pc_q, pc_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_inc;
   logic             timeout_q, timeout_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         pc_q      <= pc_nxt;
         cnt_q     <= cnt_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   // Saturating retire increment; only reachable if MAX_INSTR exceeds the counter range.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_nxt   = state_q;
      pc_nxt      = pc_q;
      cnt_nxt     = cnt_q;
      timeout_nxt = timeout_q;
      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               state_nxt   = RUN;
               pc_nxt      = start_addr;
               cnt_nxt     = '0;
               timeout_nxt = 1'b0;
            end
         end
         RUN: begin
            if (stall) begin
               state_nxt = RUN;
            end else if (halt_instr) begin
               state_nxt = HALT;
               cnt_nxt   = cnt_inc;
            end else if (cnt_q == CNT_LIMIT) begin
               state_nxt   = HALT;
               cnt_nxt     = cnt_inc;
               timeout_nxt = 1'b1;
            end else if (branch) begin
               pc_nxt  = target;
               cnt_nxt = cnt_inc;
            end else begin
               pc_nxt  = pc_q + 1'b1;
               cnt_nxt = cnt_inc;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign pc          = pc_q;
   assign instr_count = cnt_q;
   assign timeout     = timeout_q;
   assign running     = (state_q == RUN);
   assign done        = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small watchdog limit so the timeout path is reachable.
module tb_pc_sequencer;

   localparam int PC_W  = 10;
   localparam int CNT_W = 16;
   localparam int MAXI  = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [PC_W-1:0]  start_addr;
   logic             stall;
   logic             branch;
   logic [PC_W-1:0]  target;
   logic             halt_instr;
   logic [PC_W-1:0]  pc;
   logic             running;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] instr_count;

   int checks = 0;
   int passed = 0;

   pc_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .MAX_INSTR(MAXI)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .stall      (stall),
      .branch     (branch),
      .target     (target),
      .halt_instr (halt_instr),
      .pc         (pc),
      .running    (running),
      .done       (done),
      .timeout    (timeout),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Checks the full observable state in one call.
   task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_cnt,
                            input logic e_run, input logic e_done, input logic e_to);
      check({tag, ".pc"},      32'(pc),          e_pc);
      check({tag, ".count"},   32'(instr_count), e_cnt);
      check({tag, ".running"}, 32'(running),     32'(e_run));
      check({tag, ".done"},    32'(done),        32'(e_done));
      check({tag, ".timeout"}, 32'(timeout),     32'(e_to));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start_addr = '0; stall = 1'b0;
      branch = 1'b0; target = '0; halt_instr = 1'b0;
      step();
      step();
      check_all("reset", 32'h000, 0, 1'b0, 1'b0, 1'b0);

      // Inputs other than start are ignored in IDLE
      reset = 1'b0; branch = 1'b1; target = 10'h155; halt_instr = 1'b1;
      step();
      check_all("idle_ignore", 32'h000, 0, 1'b0, 1'b0, 1'b0);
      branch = 1'b0; halt_instr = 1'b0;

      start = 1'b1; start_addr = 10'h010;
      step();
      start = 1'b0;
      check_all("start", 32'h010, 0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step();
         check_all($sformatf("seq%0d", i), 32'h010 + 32'(i), 32'(i), 1'b1, 1'b0, 1'b0);
      end

      step();
      step();
      check_all("pre_halt", 32'h017, 7, 1'b1, 1'b0, 1'b0);

      // halt_instr outranks the watchdog at count == MAX-1
      halt_instr = 1'b1;
      step();
      halt_instr = 1'b0;
      check_all("halt", 32'h017, 8, 1'b0, 1'b1, 1'b0);
      branch = 1'b1; target = 10'h0AA;
      step();
      branch = 1'b0;
      check_all("halt_hold", 32'h017, 8, 1'b0, 1'b1, 1'b0);

      start = 1'b1; start_addr = 10'h020;
      step();
      start = 1'b0;
      check_all("restart", 32'h020, 0, 1'b1, 1'b0, 1'b0);

      branch = 1'b1; target = 10'h0A8;
      step();
      branch = 1'b0;
      check_all("branch", 32'h0A8, 1, 1'b1, 1'b0, 1'b0);

      stall = 1'b1; branch = 1'b1; halt_instr = 1'b1; target = 10'h155;
      for (int i = 0; i < 3; i++) begin
         step();
         check_all($sformatf("stall%0d", i), 32'h0A8, 1, 1'b1, 1'b0, 1'b0);
      end
      stall = 1'b0; branch = 1'b0; halt_instr = 1'b0;

      start = 1'b1; start_addr = 10'h300;
      step();
      start = 1'b0;
      check_all("start_in_run", 32'h0A9, 2, 1'b1, 1'b0, 1'b0);

      reset = 1'b1;
      step();
      reset = 1'b0;
      check_all("reset_mid_run", 32'h000, 0, 1'b0, 1'b0, 1'b0);

      start = 1'b1; start_addr = 10'h3FE;
      step();
      start = 1'b0;
      step();
      check_all("at_3ff", 32'h3FF, 1, 1'b1, 1'b0, 1'b0);
      step();
      check_all("wrap", 32'h000, 2, 1'b1, 1'b0, 1'b0);

      // Tight branch loop until the watchdog fires at count 7 -> 8
      branch = 1'b1; target = 10'h000;
      for (int i = 0; i < 5; i++) step();
      check_all("loop", 32'h000, 7, 1'b1, 1'b0, 1'b0);
      step();
      check_all("watchdog", 32'h000, 8, 1'b0, 1'b1, 1'b1);
      step();
      branch = 1'b0;
      check_all("watchdog_hold", 32'h000, 8, 1'b0, 1'b1, 1'b1);

      start = 1'b1; start_addr = 10'h123;
      step();
      start = 1'b0;
      check_all("restart_after_to", 32'h123, 0, 1'b1, 1'b0, 1'b0);

      reset = 1'b1;
      step();
      check_all("final_reset", 32'h000, 0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
